// File: rtl/fifo_access_scheduler.sv
// Shares one single-port FIFO between NUM_WR round-robin writers and one reader.
// Issues at most one FIFO command per clock and tracks occupancy in Level.
module fifo_access_scheduler #(
  parameter  int NUM_WR = 4,
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 32,
  localparam int LVL_W  = $clog2(DEPTH) + 1,
  localparam int PTR_W  = (NUM_WR > 1) ? $clog2(NUM_WR) : 1
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [NUM_WR-1:0]        Wr_Req,
  input  logic [NUM_WR*DATA_W-1:0] Wr_Data,
  output logic [NUM_WR-1:0]        Wr_Grant,
  input  logic                     Rd_Req,
  output logic                     Rd_Grant,
  output logic                     Rd_Valid,
  output logic [DATA_W-1:0]        Rd_Data,
  output logic [LVL_W-1:0]         Level,
  output logic                     Fifo_Enable,
  output logic                     Fifo_Read_Write,
  output logic [DATA_W-1:0]        Fifo_Input,
  input  logic [DATA_W-1:0]        Fifo_Output,
  input  logic                     Fifo_Empty,
  input  logic                     Fifo_Full
);

  typedef enum logic {PRI_READ = 1'b0, PRI_WRITE = 1'b1} pri_e;

  pri_e              pri_q, pri_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  logic             sel_found;
  logic [PTR_W-1:0] sel_idx;
  logic             rd_ok, wr_ok, do_rd, do_wr;

  // First requesting writer at or after rr_ptr, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (!sel_found && Wr_Req[(int'(rr_ptr_q) + k) % NUM_WR]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'((int'(rr_ptr_q) + k) % NUM_WR);
      end
    end
  end

  assign rd_ok = !Reset && Rd_Req && !Fifo_Empty;
  assign wr_ok = !Reset && sel_found && !Fifo_Full;
  assign do_rd = rd_ok && (!wr_ok || pri_q == PRI_READ);
  assign do_wr = wr_ok && !do_rd;

  always_comb begin
    Wr_Grant        = '0;
    Rd_Grant        = 1'b0;
    Fifo_Enable     = 1'b0;
    Fifo_Read_Write = 1'b0;
    Fifo_Input      = '0;
    pri_d           = pri_q;
    rr_ptr_d        = rr_ptr_q;
    level_d         = level_q;
    if (do_wr) begin
      Wr_Grant        = NUM_WR'(1) << sel_idx;
      Fifo_Enable     = 1'b1;
      Fifo_Read_Write = 1'b1;
      Fifo_Input      = Wr_Data[sel_idx*DATA_W +: DATA_W];
      pri_d           = PRI_READ;
      rr_ptr_d        = (sel_idx == PTR_W'(NUM_WR - 1)) ? '0 : sel_idx + 1'b1;
      level_d         = level_q + 1'b1;
    end else if (do_rd) begin
      Rd_Grant    = 1'b1;
      Fifo_Enable = 1'b1;
      pri_d       = PRI_WRITE;
      level_d     = level_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pri_q      <= PRI_WRITE;
      rr_ptr_q   <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      pri_q      <= pri_d;
      rr_ptr_q   <= rr_ptr_d;
      level_q    <= level_d;
      rd_valid_q <= do_rd;
      // Hold the last delivered word once the valid pulse ends.
      if (rd_valid_q) rd_data_q <= Fifo_Output;
    end
  end

  assign Level    = level_q;
  assign Rd_Valid = rd_valid_q;
  assign Rd_Data  = rd_valid_q ? Fifo_Output : rd_data_q;

  a_level_empty: assert property (@(posedge CLK) disable iff (Reset)
    (level_q == '0) == Fifo_Empty);
  a_level_full: assert property (@(posedge CLK) disable iff (Reset)
    (level_q == LVL_W'(DEPTH)) == Fifo_Full);
  a_one_cmd: assert property (@(posedge CLK)
    !(Rd_Grant && (Wr_Grant != '0)));

endmodule

// File: tb/tb_fifo_access_scheduler.sv
// Randomized and directed checks of fifo_access_scheduler against a queue-based
// reference; a simple registered FIFO model answers the DUT's command pins.
module tb_fifo_access_scheduler;
  localparam int NUM_WR = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic                     CLK = 1'b0;
  logic                     Reset = 1'b1;
  logic [NUM_WR-1:0]        Wr_Req = '0;
  logic [NUM_WR*DATA_W-1:0] Wr_Data = '0;
  logic [NUM_WR-1:0]        Wr_Grant;
  logic                     Rd_Req = 1'b0;
  logic                     Rd_Grant, Rd_Valid;
  logic [DATA_W-1:0]        Rd_Data;
  logic [LVL_W-1:0]         Level;
  logic                     Fifo_Enable, Fifo_Read_Write;
  logic [DATA_W-1:0]        Fifo_Input, Fifo_Output;
  logic                     Fifo_Empty, Fifo_Full;

  fifo_access_scheduler #(.NUM_WR(NUM_WR), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .Reset(Reset), .Wr_Req(Wr_Req), .Wr_Data(Wr_Data), .Wr_Grant(Wr_Grant),
    .Rd_Req(Rd_Req), .Rd_Grant(Rd_Grant), .Rd_Valid(Rd_Valid), .Rd_Data(Rd_Data),
    .Level(Level), .Fifo_Enable(Fifo_Enable), .Fifo_Read_Write(Fifo_Read_Write),
    .Fifo_Input(Fifo_Input), .Fifo_Output(Fifo_Output), .Fifo_Empty(Fifo_Empty),
    .Fifo_Full(Fifo_Full));

  always #5 CLK = ~CLK;

  // Behavioural single-port FIFO driven by the DUT's command pins.
  logic [DATA_W-1:0] fmem [DEPTH];
  int                fwp = 0, frp = 0, fcnt = 0;
  logic [DATA_W-1:0] fout = '0;
  assign Fifo_Output = fout;
  assign Fifo_Empty  = (fcnt == 0);
  assign Fifo_Full   = (fcnt == DEPTH);

  always @(posedge CLK) begin
    if (Reset) begin
      fwp <= 0; frp <= 0; fcnt <= 0; fout <= '0;
    end else if (Fifo_Enable) begin
      if (Fifo_Read_Write) begin
        if (fcnt < DEPTH) begin
          fmem[fwp] <= Fifo_Input;
          fwp       <= (fwp + 1) % DEPTH;
          fcnt      <= fcnt + 1;
        end
      end else if (fcnt > 0) begin
        fout <= fmem[frp];
        frp  <= (frp + 1) % DEPTH;
        fcnt <= fcnt - 1;
      end
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference state: contents of the FIFO as a queue, plus scheduler bookkeeping.
  logic [DATA_W-1:0] exp_q [$];
  bit                m_wpri = 1'b1;
  int                m_rr   = 0;
  bit                m_rv   = 1'b0;
  logic [DATA_W-1:0] m_rdata = '0, m_hold = '0;

  task automatic cyc(input bit rst, input logic [NUM_WR-1:0] wreq,
                     input logic [NUM_WR*DATA_W-1:0] wdat, input bit rreq);
    bit rd_ok, wr_ok, do_rd, do_wr;
    int sel;
    logic [DATA_W-1:0] din;
    logic [NUM_WR-1:0] g;
    @(negedge CLK);
    Reset = rst; Wr_Req = wreq; Wr_Data = wdat; Rd_Req = rreq;
    #1;
    sel = -1;
    for (int k = 0; k < NUM_WR; k++)
      if (sel < 0 && wreq[(m_rr + k) % NUM_WR]) sel = (m_rr + k) % NUM_WR;
    rd_ok = !rst && rreq && exp_q.size() > 0;
    wr_ok = !rst && sel >= 0 && exp_q.size() < DEPTH;
    do_rd = rd_ok && (!wr_ok || !m_wpri);
    do_wr = wr_ok && !do_rd;
    din = '0;
    g   = '0;
    if (do_wr) begin
      din    = wdat[sel*DATA_W +: DATA_W];
      g[sel] = 1'b1;
    end
    chk("wr_grant", 32'(Wr_Grant), 32'(g));
    chk("rd_grant", 32'(Rd_Grant), 32'(do_rd));
    chk("fifo_en", 32'(Fifo_Enable), 32'(do_rd || do_wr));
    chk("fifo_rw", 32'(Fifo_Read_Write), 32'(do_wr));
    chk("fifo_in", 32'(Fifo_Input), 32'(din));
    chk("level", 32'(Level), 32'(exp_q.size()));
    chk("rd_valid", 32'(Rd_Valid), 32'(m_rv));
    chk("rd_data", 32'(Rd_Data), 32'(m_rv ? m_rdata : m_hold));
    if (rst) begin
      exp_q.delete(); m_wpri = 1'b1; m_rr = 0; m_rv = 1'b0; m_hold = '0;
    end else begin
      if (m_rv) m_hold = m_rdata;
      m_rv = do_rd;
      if (do_rd) begin m_rdata = exp_q.pop_front(); m_wpri = 1'b1; end
      if (do_wr) begin exp_q.push_back(din); m_rr = (sel + 1) % NUM_WR; m_wpri = 1'b0; end
    end
  endtask

  logic [NUM_WR*DATA_W-1:0] d10;
  bit seq_rw [4];

  initial begin
    d10 = {8'h13, 8'h12, 8'h11, 8'h10};
    seq_rw = '{1'b1, 1'b0, 1'b1, 1'b0};
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_level", 32'(Level), 32'd0);
    chk("rst_rvalid", 32'(Rd_Valid), 32'd0);
    chk("rst_rdata", 32'(Rd_Data), 32'd0);

    // Single write then single read of A5
    cyc(0, 4'b0001, 32'h0000_00A5, 0);
    chk("t1_grant", 32'(Wr_Grant), 32'b0001);
    chk("t1_in", 32'(Fifo_Input), 32'hA5);
    cyc(0, 4'b0000, '0, 1);
    chk("t2_level", 32'(Level), 32'd1);
    chk("t2_rdgrant", 32'(Rd_Grant), 32'd1);
    cyc(0, 4'b0000, '0, 0);
    chk("t2_rvalid", 32'(Rd_Valid), 32'd1);
    chk("t2_rdata", 32'(Rd_Data), 32'hA5);
    chk("t2_level0", 32'(Level), 32'd0);
    cyc(0, 4'b0000, '0, 0);
    chk("t2_hold", 32'(Rd_Data), 32'hA5);

    // Fill from four writers, round-robin, until full
    cyc(1, '0, '0, 0);
    for (int i = 0; i < 34; i++) begin
      cyc(0, 4'b1111, d10, 0);
      if (i < 8) chk("rr_order", 32'(Wr_Grant), 32'(4'b0001 << (i % 4)));
    end
    chk("full_level", 32'(Level), 32'd32);
    chk("full_flag", 32'(Fifo_Full), 32'd1);
    chk("full_stall", 32'(Wr_Grant), 32'd0);

    // Contention alternation starting from PRI_WRITE with 2 entries
    cyc(1, '0, '0, 0);
    repeat (3) cyc(0, 4'b0001, 32'h77, 0);
    cyc(0, 4'b0000, '0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 4'b0001, 32'h5C, 1);
      chk("alt_rw", 32'(Fifo_Read_Write), 32'(seq_rw[i]));
      chk("alt_lvl", 32'(Level), (i % 2 == 0) ? 32'd2 : 32'd3);
    end

    // Empty read stalls
    cyc(1, '0, '0, 0);
    repeat (3) begin
      cyc(0, '0, '0, 1);
      chk("empty_en", 32'(Fifo_Enable), 32'd0);
    end

    // Reset right after a read issue at Level 5
    cyc(1, '0, '0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 4'b0001, 32'(i + 1), 0);
    cyc(0, '0, '0, 1);
    cyc(1, 4'b0010, 32'h1111, 1);
    chk("mid_rst_grant", 32'(Wr_Grant), 32'd0);
    cyc(0, 4'b1111, d10, 0);
    chk("mid_rst_rvalid", 32'(Rd_Valid), 32'd0);
    chk("mid_rst_level", 32'(Level), 32'd0);
    chk("post_rst_w0", 32'(Wr_Grant), 32'b0001);

    // Randomized traffic with drifting read/write bias
    for (int i = 0; i < 2000; i++) begin
      int rd_pct, wr_pct;
      rd_pct = ((i / 150) % 3 == 0) ? 20 : (((i / 150) % 3 == 1) ? 80 : 50);
      wr_pct = 100 - rd_pct;
      cyc(($urandom_range(0, 299) == 0),
          NUM_WR'(($urandom_range(0, 99) < wr_pct) ? $urandom_range(1, 15) : 0),
          NUM_WR*DATA_W'($urandom),
          ($urandom_range(0, 99) < rd_pct));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
